// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 keyboard-side transmitter: byte FIFO feeding a device-clocked 11-bit serial frame
module ps2_kbd_tx #(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          force_bad_parity,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [7:0]    head;

    state_t        state, state_n;
    logic [3:0]    bit_idx, bit_n;
    logic          phase, phase_n;     // 1 = HIGH half, 0 = LOW half
    logic [TW-1:0] timer, timer_n;
    logic [10:0]   frame, frame_n;
    logic          ps2_clk_n, ps2_data_n;

    assign in_ready   = (count < CW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign busy       = (state != IDLE);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            phase    <= 1'b1;
            timer    <= '0;
            frame    <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_n;
            phase    <= phase_n;
            timer    <= timer_n;
            frame    <= frame_n;
            ps2_clk  <= ps2_clk_n;
            ps2_data <= ps2_data_n;
        end
    end

    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        phase_n = phase;
        timer_n = timer;
        frame_n = frame;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    frame_n = {1'b1, (~^head) ^ force_bad_parity, head, 1'b0};
                    state_n = SEND;
                    bit_n   = 4'd0;
                    phase_n = 1'b1;
                    timer_n = '0;
                end
            end
            SEND: begin
                if (timer == TW'(HALF_PERIOD - 1)) begin
                    timer_n = '0;
                    if (phase) begin
                        phase_n = 1'b0;
                    end else if (bit_idx == 4'd10) begin
                        state_n = GAP;
                        bit_n   = 4'd0;
                        phase_n = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 4'd1;
                        phase_n = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Line levels are registered from the next state so they switch on the same edge as the FSM.
        ps2_clk_n  = (state_n == SEND) ? phase_n : 1'b1;
        ps2_data_n = (state_n == SEND) ? frame_n[bit_n] : 1'b1;
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb/tb_ps2_kbd_tx.sv - self-checking bench for ps2_kbd_tx against a frame-level reference model
module tb_ps2_kbd_tx;
    localparam int HP = 4;
    localparam int GC = 8;
    localparam int FD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       force_bad_parity;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic [3:0] fifo_count;

    ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .force_bad_parity(force_bad_parity), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cyc = 0;
    int idle_run = 0;
    int last_gap = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cyc++;
        if (ps2_clk === 1'b1 && ps2_data === 1'b1) begin
            idle_run++;
        end else begin
            if (ps2_clk === 1'b1 && ps2_data === 1'b0 && idle_run > 0) last_gap = idle_run;
            idle_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ref_frame(input logic [7:0] b, input logic bad);
        logic p;
        p = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, p ^ bad, b, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic bad);
        int g;
        in_data = b;
        force_bad_parity = bad;
        in_valid = 1'b1;
        g = 0;
        while (in_ready !== 1'b1 && g < 500) begin
            tick();
            g++;
        end
        chk("push_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        force_bad_parity = 1'b0;
    endtask

    task automatic rx(output logic [10:0] bits, output int first_fall, output logic ok);
        logic prev;
        int n, cyc;
        prev = ps2_clk;
        n = 0;
        cyc = 0;
        bits = '0;
        first_fall = -1;
        while (n < 11 && cyc < 2000) begin
            tick();
            cyc++;
            if (prev === 1'b1 && ps2_clk === 1'b0) begin
                bits[n] = ps2_data;
                if (n == 0) first_fall = cyc;
                n++;
            end
            prev = ps2_clk;
        end
        ok = (n == 11);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 2000) begin
            tick();
            g++;
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  b;
        logic        bad, ok, prev;
        int          ff, nf, g, max_cnt;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        force_bad_parity = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", fifo_count, 0);

        busy_cyc = 0;
        push(8'h1C, 1'b0);
        rx(bits, ff, ok);
        chk("1c_complete", ok, 1);
        chk("1c_bits_const", bits, 11'b100_0011_1000);
        chk("1c_bits_model", bits, ref_frame(8'h1C, 1'b0));
        chk("1c_first_fall", ff, HP);
        wait_idle();
        chk("1c_busy_cycles", busy_cyc, 22 * HP + GC);

        push(8'hF0, 1'b0);
        rx(bits, ff, ok);
        chk("f0_complete", ok, 1);
        chk("f0_bits_const", bits, 11'b111_1110_0000);
        wait_idle();
        push(8'hF0, 1'b1);
        rx(bits, ff, ok);
        chk("f0bad_bits_model", bits, ref_frame(8'hF0, 1'b1));
        chk("f0bad_parity", bits[9], 0);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            bad = 1'($urandom_range(0, 1));
            push(b, bad);
            rx(bits, ff, ok);
            chk("rand_complete", ok, 1);
            chk("rand_bits", bits, ref_frame(b, bad));
            wait_idle();
        end

        max_cnt = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    in_data = 8'h40 + 8'(i * 7);
                    in_valid = 1'b1;
                    g = 0;
                    forever begin
                        chk("ready_vs_count", in_ready, (fifo_count < FD) ? 1 : 0);
                        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
                        if (in_ready === 1'b1 || g >= 1000) break;
                        tick();
                        g++;
                    end
                    exp_q.push_back(in_data);
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    logic [10:0] fb;
                    int          fff;
                    logic        fok;
                    rx(fb, fff, fok);
                    chk("burst_complete", fok, 1);
                    if (exp_q.size() == 0) begin
                        chk("burst_queue_nonempty", 0, 1);
                    end else begin
                        chk("burst_order", fb, ref_frame(exp_q.pop_front(), 1'b0));
                    end
                    if (k > 0) chk("burst_gap_ge", (last_gap >= GC) ? 1 : 0, 1);
                end
            end
        join
        chk("burst_max_count", max_cnt, FD);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            in_data = 8'h1C + 8'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        prev = ps2_clk;
        nf = 0;
        g = 0;
        while (nf < 5 && g < 1000) begin
            tick();
            g++;
            if (prev === 1'b1 && ps2_clk === 1'b0) nf++;
            prev = ps2_clk;
        end
        chk("abort_reached_5th_fall", nf, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ps2_clk", ps2_clk, 1);
        chk("abort_ps2_data", ps2_data, 1);
        chk("abort_count", fifo_count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        prev = ps2_clk;
        nf = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (prev === 1'b1 && ps2_clk === 1'b0) nf++;
            prev = ps2_clk;
        end
        chk("abort_no_edges", nf, 0);

        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_push_discard_count", fifo_count, 0);
        chk("rst_push_discard_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
